sw_debounce: RTL
================

// Module: sw_debounce
// PURPOSE
//  Input conditioner for the slide switches / keys feeding io_sw_i of single_cycle.
//  Synchronises asynchronous raw inputs, debounces each bit against a shared sample tick,
//  and emits one-cycle rise/fall pulses. Sits between the board pins and the core's io_sw_i.
// PARAMETERS
//  W           32      number of switch bits (independent channels)
//  TICK_DIV    50000   clk cycles per sample tick (1 ms @ 50 MHz); legal range >= 1
//  STABLE_CNT  4       consecutive differing ticks required to accept a new level; >= 1
// PORTS
//  clk_i       in   1      system clock
//  rst_ni      in   1      synchronous reset, active low
//  sw_raw_i    in   W      raw asynchronous switch levels from pins
//  sw_db_o     out  W      debounced levels -> single_cycle.io_sw_i
//  sw_rise_o   out  W      1-cycle pulse per bit on accepted 0->1
//  sw_fall_o   out  W      1-cycle pulse per bit on accepted 1->0
//  tick_o      out  1      sample tick strobe (debug / shared timebase)
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): sync FFs, tick counter, per-bit counters, sw_db_o,
//   sw_rise_o, sw_fall_o, tick_o all cleared to 0, regardless of sw_raw_i.
//  Sync: two-flop synchroniser per bit; sync_q = sw_raw_i delayed 2 clk.
//  Tick counter: counts 0..TICK_DIV-1, wraps to 0; tick_o registered high for exactly one
//   clk when counter == TICK_DIV-1. First tick after reset release: TICK_DIV-th clk.
//   TICK_DIV=1 -> tick_o high every clk after the first post-reset edge.
//  Per bit i, evaluated only on cycles where tick_o=1 (else all state holds):
//   - sync_q[i] == sw_db_o[i]: cnt[i] <= 0 (any agreeing sample restarts the count)
//   - sync_q[i] != sw_db_o[i] and cnt[i] < STABLE_CNT-1: cnt[i] <= cnt[i]+1
//   - sync_q[i] != sw_db_o[i] and cnt[i] == STABLE_CNT-1: sw_db_o[i] <= sync_q[i],
//     cnt[i] <= 0, and rise/fall pulse per direction
//  cnt width = $clog2(STABLE_CNT+1); cnt never exceeds STABLE_CNT-1.
//  Pulses: sw_rise_o[i]/sw_fall_o[i] registered on the same edge that updates sw_db_o[i];
//   high exactly one clk, deasserted on the next edge. Never both high for one bit.
//  Latency: new stable level appears on sw_db_o at the STABLE_CNT-th tick whose sample
//   differs; worst case 2 + STABLE_CNT*TICK_DIV clk from pin change.
//  Channels fully independent; any mix of bits may update/pulse on the same tick.
//  Reset mid-operation: partial counts discarded; accepting a level needs full STABLE_CNT
//   ticks again; tick phase restarts at 0.
//  No combinational path from sw_raw_i to any output; all outputs registered.
// TESTING (bench params TICK_DIV=4, STABLE_CNT=3, W=32)
//  1 Reset with sw_raw_i=FFFFFFFF, release -> sw_db_o=0 until 3rd tick (clk 12 after
//    release), then FFFFFFFF; sw_rise_o=FFFFFFFF for that one clk; sw_fall_o=0 throughout.
//  2 Glitch: bit0 high for 2 ticks then low -> sw_db_o[0] stays 0, no rise/fall pulses.
//  3 Fall: from sw_db_o=00000020, drop bit5 -> sw_db_o[5]=0 on 3rd differing tick,
//    sw_fall_o=00000020 one clk, cycle-exact vs reference model.
//  4 Independence: bit0 toggles each tick while bit31 rises stably -> only bit31 updates
//    (sw_db_o=80000000, sw_rise_o=80000000 one clk); bit0 never accepted.
//  5 Reset mid-count: after 2 differing ticks on bit7, pulse rst_ni low 1 clk -> sw_db_o=0,
//    bit7 accepted only after 3 further ticks (12 clk); tick_o phase restarts.
//  6 TICK_DIV=1 build: raw bit3 rise -> sw_db_o[3]=1 exactly 3 ticks after sync, tick_o
//    constantly high post-reset; random stimulus scoreboard vs model, 10k cycles, no mismatch.

Source files
------------

// File: rtl/sw_debounce.sv
// sw_debounce: switch/key input conditioner.
// Each raw pin passes through a two-flop synchroniser. It is then debounced against a
// shared sample tick. A new level is accepted only after STABLE_CNT consecutive ticks
// whose sample differs from the current debounced level. Every accepted change
// produces a one-clock rise or fall pulse. All outputs are registered.
module sw_debounce #(
    parameter int W          = 32,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] sw_raw_i,
    output logic [W-1:0] sw_db_o,
    output logic [W-1:0] sw_rise_o,
    output logic [W-1:0] sw_fall_o,
    output logic         tick_o
);

    // Tick counter is at least one bit wide so that TICK_DIV=1 still elaborates cleanly.
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);

    // Synchroniser stages: sync_p1 is the metastability-safe copy of the pins.
    logic [W-1:0]  sync_p0;
    logic [W-1:0]  sync_p1;

    logic [TW-1:0] tick_cnt;

    // Per-bit count of consecutive differing ticks, plus next-state values.
    logic [CW-1:0] cnt     [W];
    logic [CW-1:0] cnt_nxt [W];
    logic [W-1:0]  db_nxt;
    logic [W-1:0]  rise_nxt;
    logic [W-1:0]  fall_nxt;

    // Two-flop synchroniser on every raw input bit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= sw_raw_i;
            sync_p1 <= sync_p0;
        end
    end

    // Free-running timebase: tick_o is high for the one clock after the counter wraps.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tick_cnt <= '0;
            tick_o   <= 1'b0;
        end else begin
            tick_o <= (tick_cnt == TICK_LAST);
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    // Per-bit debounce decision.
    // Evaluated only while tick_o is high; otherwise counts and levels hold and pulses clear.
    always_comb begin
        db_nxt   = sw_db_o;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < W; i++) begin
            cnt_nxt[i] = cnt[i];
            if (tick_o) begin
                if (sync_p1[i] == sw_db_o[i]) begin
                    // An agreeing sample throws away any partial run of differing samples.
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt_nxt[i]  = '0;
                    db_nxt[i]   = sync_p1[i];
                    rise_nxt[i] = sync_p1[i];
                    fall_nxt[i] = ~sync_p1[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Debounced level, edge pulses and per-bit counters.
    // Pulses are registered on the same edge that updates sw_db_o.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sw_db_o   <= '0;
            sw_rise_o <= '0;
            sw_fall_o <= '0;
            for (int i = 0; i < W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_db_o   <= db_nxt;
            sw_rise_o <= rise_nxt;
            sw_fall_o <= fall_nxt;
            for (int i = 0; i < W; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule
